// File: rtl/lcd_msg_formatter.sv
// Binary-to-ASCII row formatter for the 16x2 LCD driver: "<LABEL><right-aligned decimal>".
// Define FORMATTER_SIGNED_EN to treat value as two's complement with a leading "-".
module lcd_msg_formatter #(
  parameter int VALUE_WIDTH = 16,
  parameter int DIGITS      = 5,
  parameter int LABEL_LEN   = 10,
  parameter logic [8*LABEL_LEN-1:0] LABEL = "Distance: "
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [VALUE_WIDTH-1:0] value,
  output logic                   busy,
  output logic                   done,
  output logic [127:0]           msg
);
  localparam int BW = 4*(DIGITS+1);
  localparam int CW = $clog2(VALUE_WIDTH+1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Field char for BCD digit k (0 = units) lives at field[8*k +: 8].
  function automatic logic [127:0] build_msg(input logic [8*DIGITS-1:0] f);
    logic [127:0] m;
    m = {16{8'h20}};
    for (int i = 0; i < LABEL_LEN; i++) m[127-8*i -: 8] = LABEL[8*(LABEL_LEN-1-i) +: 8];
    for (int i = 0; i < DIGITS; i++) m[127-8*(LABEL_LEN+i) -: 8] = f[8*(DIGITS-1-i) +: 8];
    return m;
  endfunction

  function automatic logic [8*DIGITS-1:0] rst_field();
    logic [8*DIGITS-1:0] f;
    f = {DIGITS{8'h20}};
    f[7:0] = 8'h30;
    return f;
  endfunction

  function automatic logic [BW+VALUE_WIDTH-1:0] dd_step(input logic [BW-1:0] b_in,
                                                         input logic [VALUE_WIDTH-1:0] sh);
    logic [BW-1:0] b;
    b = b_in;
    for (int n = 0; n <= DIGITS; n++) if (b[4*n +: 4] >= 4'd5) b[4*n +: 4] = b[4*n +: 4] + 4'd3;
    return {b, sh} << 1;
  endfunction

  localparam logic [127:0] RST_MSG = build_msg(rst_field());

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_EMIT, S_DONE} state_t;

  state_t                 state;
  logic [VALUE_WIDTH-1:0] shreg;
  logic [BW-1:0]          bcd;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   seen;
  logic [8*DIGITS-1:0]    field;
  logic [VALUE_WIDTH-1:0] mag;
  logic [3:0]             nib;
  logic                   ovf;
  logic [7:0]             ch;

  assign nib = bcd[{idx, 2'b00} +: 4];

`ifdef FORMATTER_SIGNED_EN
  logic neg;
  int   ndig;

  assign mag = value[VALUE_WIDTH-1] ? (~value + 1'b1) : value;

  // Count of displayed digits; the sign goes in the field slot just above them.
  always_comb begin
    ndig = 1;
    for (int i = 0; i < DIGITS; i++) if (bcd[4*i +: 4] != 4'd0) ndig = i + 1;
  end

  assign ovf = (bcd[BW-1 -: 4] != 4'd0) || (neg && ndig == DIGITS);
`else
  assign mag = value;
  assign ovf = (bcd[BW-1 -: 4] != 4'd0);
`endif

  always_comb begin
    if (ovf)                                     ch = 8'h2D;
    else if (nib != 4'd0 || seen || idx == '0)   ch = 8'h30 + {4'h0, nib};
`ifdef FORMATTER_SIGNED_EN
    else if (neg && int'(idx) == ndig)           ch = 8'h2D;
`endif
    else                                         ch = 8'h20;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      msg   <= RST_MSG;
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
      idx   <= '0;
      seen  <= 1'b0;
      field <= '0;
`ifdef FORMATTER_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          shreg <= mag;
          bcd   <= '0;
          cnt   <= CW'(VALUE_WIDTH);
          busy  <= 1'b1;
          state <= S_CONVERT;
`ifdef FORMATTER_SIGNED_EN
          neg   <= value[VALUE_WIDTH-1];
`endif
        end
        S_CONVERT: begin
          {bcd, shreg} <= dd_step(bcd, shreg);
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= S_EMIT;
            idx   <= IW'(DIGITS-1);
            seen  <= 1'b0;
          end
        end
        S_EMIT: begin
          field[{idx, 3'b000} +: 8] <= ch;
          seen <= seen | (nib != 4'd0);
          if (idx == '0) state <= S_DONE;
          else           idx   <= idx - 1'b1;
        end
        S_DONE: begin
          msg   <= build_msg(field);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
